// File: rtl/cmd_rx_framer_pkg.sv
// Shared controller command definitions: command byte codes and the payload
// rule the receive framer uses to size each frame.
package cmd_rx_framer_pkg;

    localparam logic [7:0] cmd_set_register    = 8'h01;
    localparam logic [7:0] cmd_rw_adconf       = 8'h02;
    localparam logic [7:0] cmd_toggle_mcp      = 8'h03;
    localparam logic [7:0] cmd_toggle_read_ccd = 8'h04;
    localparam logic [7:0] cmd_open_shutter    = 8'h05;
    localparam logic [7:0] cmd_close_shutter   = 8'h06;
    localparam logic [7:0] cmd_reset           = 8'h07;

    // Only register writes and ADC configuration carry an MSB/LSB payload.
    function automatic logic has_payload(input logic [7:0] code);
        logic result;
        case (code)
            cmd_set_register: result = 1'b1;
            cmd_rw_adconf:    result = 1'b1;
            default:          result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cmd_rx_framer_chk.sv
// Protocol checker for cmd_rx_framer: FIFO pop safety, frame hold stability
// and error pulse shape.
module cmd_rx_framer_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       rx_rempty,
    input logic       rx_rinc,
    input logic       cmd_valid,
    input logic       cmd_ready,
    input logic [7:0] cmd_code,
    input logic [7:0] cmd_msb,
    input logic [7:0] cmd_lsb,
    input logic       busy,
    input logic       err_timeout
);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        rx_rempty |-> !rx_rinc);

    a_no_pop_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
        cmd_valid |-> !rx_rinc);

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_valid && !cmd_ready) |=> (cmd_valid && $stable(cmd_code)
                                       && $stable(cmd_msb) && $stable(cmd_lsb)));

    a_valid_busy_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(cmd_valid && busy));

    a_pulse_single: assert property (@(posedge clk) disable iff (!rst_n)
        err_timeout |=> !err_timeout);

endmodule

// File: rtl/cmd_rx_framer.sv
// Pops bytes from the RX FIFO and assembles 1- or 3-byte command frames for
// the dispatcher; partial frames are dropped after an inactivity timeout.
module cmd_rx_framer
    import cmd_rx_framer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rempty,
    input  logic [7:0] rx_rdata,
    output logic       rx_rinc,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_msb,
    output logic [7:0] cmd_lsb,
    output logic       busy,
    output logic       err_timeout,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MSB  = 2'd1,
        S_LSB  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   timer_nxt_s;
    logic            pop_s;
    logic            waiting_s;
    logic            expire_s;
    logic [7:0]      code_r;
    logic [7:0]      msb_r;
    logic [7:0]      lsb_r;
    logic [7:0]      code_nxt_s;
    logic [7:0]      msb_nxt_s;
    logic [7:0]      lsb_nxt_s;
    logic [7:0]      err_count_r;
    logic [7:0]      err_count_nxt_s;
    logic            valid_r;
    logic            busy_r;
    logic            err_timeout_r;

    // Pop qualification and timeout detection; a byte on the expiry cycle wins.
    always_comb begin
        pop_s     = (!rx_rempty) && (state_r != S_HOLD);
        waiting_s = (state_r == S_MSB) || (state_r == S_LSB);
        expire_s  = waiting_s && rx_rempty && (timer_r == TIMER_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = has_payload(rx_rdata) ? S_MSB : S_HOLD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MSB: begin
                if (pop_s) begin
                    state_nxt_s = S_LSB;
                end else if (expire_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_MSB;
                end
            end
            S_LSB: begin
                if (pop_s) begin
                    state_nxt_s = S_HOLD;
                end else if (expire_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_LSB;
                end
            end
            S_HOLD: begin
                if (cmd_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Inactivity timer only counts empty cycles while mid-frame.
    always_comb begin
        timer_nxt_s = timer_r;
        if (pop_s || !waiting_s || expire_s) begin
            timer_nxt_s = {TW{1'b0}};
        end else begin
            timer_nxt_s = timer_r + TW'(1);
        end
    end

    // Frame field capture; dropped frames leave stale contents behind.
    always_comb begin
        code_nxt_s = code_r;
        msb_nxt_s  = msb_r;
        lsb_nxt_s  = lsb_r;
        if (pop_s) begin
            case (state_r)
                S_IDLE: begin
                    code_nxt_s = rx_rdata;
                    if (!has_payload(rx_rdata)) begin
                        msb_nxt_s = 8'h00;
                        lsb_nxt_s = 8'h00;
                    end else begin
                        msb_nxt_s = msb_r;
                        lsb_nxt_s = lsb_r;
                    end
                end
                S_MSB:   msb_nxt_s = rx_rdata;
                S_LSB:   lsb_nxt_s = rx_rdata;
                default: code_nxt_s = code_r;
            endcase
        end else begin
            code_nxt_s = code_r;
        end
    end

    // Saturating count of dropped frames.
    always_comb begin
        err_count_nxt_s = err_count_r;
        if (expire_s && (err_count_r != 8'hFF)) begin
            err_count_nxt_s = err_count_r + 8'd1;
        end else begin
            err_count_nxt_s = err_count_r;
        end
    end

    // State, timer, data and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            timer_r       <= {TW{1'b0}};
            code_r        <= 8'h00;
            msb_r         <= 8'h00;
            lsb_r         <= 8'h00;
            err_count_r   <= 8'h00;
            valid_r       <= 1'b0;
            busy_r        <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            timer_r       <= timer_nxt_s;
            code_r        <= code_nxt_s;
            msb_r         <= msb_nxt_s;
            lsb_r         <= lsb_nxt_s;
            err_count_r   <= err_count_nxt_s;
            valid_r       <= (state_nxt_s == S_HOLD);
            busy_r        <= (state_nxt_s == S_MSB) || (state_nxt_s == S_LSB);
            err_timeout_r <= expire_s;
        end
    end

    assign rx_rinc     = pop_s;
    assign cmd_valid   = valid_r;
    assign cmd_code    = code_r;
    assign cmd_msb     = msb_r;
    assign cmd_lsb     = lsb_r;
    assign busy        = busy_r;
    assign err_timeout = err_timeout_r;
    assign err_count   = err_count_r;

endmodule
